// File: rtl/present_key_schedule.sv
// Sequential PRESENT round-key generator: loads the user key, presents K1 and steps K2..K32 on each 'next'.
// Latency: load or next sampled at edge n gives the new key on the outputs right after edge n; one key per cycle.
// Backpressure: none; 'next' is ignored outside RUN and 'load' always wins. PRESENT_KEY128_EN selects the 128-bit key.
module present_key_schedule #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] key_in,
    input  logic         next,
    output logic [63:0]  round_key,
    output logic [5:0]   round_idx,
    output logic         valid,
    output logic         done
);

`ifdef PRESENT_KEY128_EN
    localparam int KW = 128;
`else
    localparam int KW = 80;
`endif

    // Key on round_idx == LAST_IDX is the one whose 'next' produces the final key
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   kreg_q,  kreg_d;
    logic [5:0]      round_idx_q, round_idx_d;
    logic [KW-1:0]   kreg_upd;

`ifndef PRESENT_KEY128_EN
    // Upper user-key bits have no destination in the 80-bit register
    logic key_hi_unused;
    assign key_hi_unused = ^key_in[127:KW];
`endif

    // PRESENT 4-bit S-box, kept local so the key path does not depend on the datapath layer
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One key-register update: rotate left by 61, S-box the top nibble(s), fold in the round counter
    function automatic logic [KW-1:0] key_update(input logic [KW-1:0] k, input logic [4:0] cnt);
        logic [KW-1:0] r;
`ifdef PRESENT_KEY128_EN
        r            = {k[66:0], k[127:67]};
        r[127:124]   = sbox(r[127:124]);
        r[123:120]   = sbox(r[123:120]);
        r[66:62]     = r[66:62] ^ cnt;
`else
        r            = {k[18:0], k[79:19]};
        r[79:76]     = sbox(r[79:76]);
        r[19:15]     = r[19:15] ^ cnt;
`endif
        return r;
    endfunction

    // Candidate next key; the counter is the index of the key currently presented
    always_comb begin
        kreg_upd = key_update(kreg_q, round_idx_q[4:0]);
    end

    // Next-state logic: load has priority, next only advances in RUN
    always_comb begin
        state_d     = state_q;
        kreg_d      = kreg_q;
        round_idx_d = round_idx_q;
        if (load) begin
            kreg_d      = key_in[KW-1:0];
            round_idx_d = 6'd1;
            state_d     = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (next) begin
                        kreg_d      = kreg_upd;
                        round_idx_d = round_idx_q + 6'd1;
                        if (round_idx_q == LAST_IDX) begin
                            state_d = ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    state_d = ST_LAST;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, key register and round index; everything clears asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kreg_q      <= '0;
            round_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            kreg_q      <= kreg_d;
            round_idx_q <= round_idx_d;
        end
    end

    // Outputs decode registered state only
    assign round_key = kreg_q[KW-1 -: 64];
    assign round_idx = round_idx_q;
    assign valid     = (state_q != ST_IDLE);
    assign done      = (state_q == ST_LAST);

endmodule

// File: tb/tb_present_key_schedule.sv
module tb_present_key_schedule;

`ifdef PRESENT_KEY128_EN
    localparam int KW = 128;
`else
    localparam int KW = 80;
`endif

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [127:0] key_in;
    logic         next;
    logic [63:0]  round_key;
    logic [5:0]   round_idx;
    logic         valid;
    logic         done;

    present_key_schedule #(.ROUNDS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .key_in    (key_in),
        .next      (next),
        .round_key (round_key),
        .round_idx (round_idx),
        .valid     (valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] rk;
        logic [5:0]  idx;
        logic        v;
        logic        d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int            m_state;   // 0 idle, 1 run, 2 last
    logic [127:0]  m_kreg;
    int            m_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] ref_s(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'hC56B90AD3EF84712;
        return tbl[63 - 4*int'(x) -: 4];
    endfunction

    function automatic logic [127:0] ref_update(input logic [127:0] k, input int cnt);
        logic [127:0] r;
        logic [4:0]   c;
        r = '0;
        c = cnt[4:0];
        for (int i = 0; i < KW; i++) r[(i + 61) % KW] = k[i];
`ifdef PRESENT_KEY128_EN
        r[127:124] = ref_s(r[127:124]);
        r[123:120] = ref_s(r[123:120]);
        for (int b = 0; b < 5; b++) r[62 + b] = r[62 + b] ^ c[b];
`else
        r[79:76] = ref_s(r[79:76]);
        for (int b = 0; b < 5; b++) r[15 + b] = r[15 + b] ^ c[b];
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_kreg  = '0;
        m_idx   = 0;
    endtask

    task automatic model_step(input logic ld, input logic nx, input logic [127:0] k);
        if (ld) begin
            m_kreg  = '0;
            m_kreg[KW-1:0] = k[KW-1:0];
            m_idx   = 1;
            m_state = 1;
        end else if (m_state == 1 && nx) begin
            m_kreg = ref_update(m_kreg, m_idx);
            if (m_idx == 31) m_state = 2;
            m_idx  = m_idx + 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.rk  = m_kreg[KW-1 -: 64];
        e.idx = 6'(m_idx);
        e.v   = (m_state != 0);
        e.d   = (m_state == 2);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("round_key", round_key, e.rk);
            check("round_idx", 64'(round_idx), 64'(e.idx));
            check("valid", 64'(valid), 64'(e.v));
            check("done", 64'(done), 64'(e.d));
        end
    endtask

    task automatic drive_cycle(input logic ld, input logic nx, input logic [127:0] k);
        @(negedge clk);
        load   = ld;
        next   = nx;
        key_in = k;
        model_step(ld, nx, k);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        logic [127:0] rkey;
        int           done_at;

        rst_n  = 1'b0;
        load   = 1'b0;
        next   = 1'b0;
        key_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_round_key", round_key, 64'd0);
        check("rst_round_idx", 64'(round_idx), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // next while IDLE has no effect
        drive_cycle(1'b0, 1'b1, '0);
        drive_cycle(1'b0, 1'b1, '0);

        // Known vectors from the all-zero key
        drive_cycle(1'b1, 1'b0, '0);
        check("kat_k1_zero", round_key, 64'h0000000000000000);
        drive_cycle(1'b0, 1'b1, '0);
`ifdef PRESENT_KEY128_EN
        check("kat_k2_zero128", round_key, 64'hCC00000000000000);
`else
        check("kat_k2_zero80", round_key, 64'hC000000000000000);
`endif
        check("kat_idx2", 64'(round_idx), 64'd2);

`ifndef PRESENT_KEY128_EN
        // All-ones 80-bit key
        drive_cycle(1'b1, 1'b0, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF});
        drive_cycle(1'b0, 1'b1, '0);
        check("kat_k2_ones80", round_key, 64'h2FFFFFFFFFFFFFFF);
`endif

        // Full schedule with next held for 40 cycles
        rkey = {$urandom, $urandom, $urandom, $urandom};
        drive_cycle(1'b1, 1'b0, rkey);
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 1'b1, '0);
            if (done && done_at < 0) done_at = i + 1;
        end
        check("done_latency", 64'(done_at), 64'd31);

        // load and next together mid-schedule: load wins
        rkey = {$urandom, $urandom, $urandom, $urandom};
        drive_cycle(1'b1, 1'b0, rkey);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, '0);
        rkey = {$urandom, $urandom, $urandom, $urandom};
        drive_cycle(1'b1, 1'b1, rkey);
        check("ld_nx_idx", 64'(round_idx), 64'd1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, '0);

        // Asynchronous reset between edges mid-schedule
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_round_key", round_key, 64'd0);
        check("arst_round_idx", 64'(round_idx), 64'd0);
        check("arst_valid", 64'(valid), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, '0);

        @(negedge clk);
        load = 1'b0;
        next = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
